// File: rtl/draw_sequencer_pkg.sv
// Shared types and constants for the draw sequencer and its pixel mux.
package draw_sequencer_pkg;

    // Screen geometry; coordinate widths are derived from it.
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam int X_W = $clog2(SCREEN_W);  // 9 bits
    localparam int Y_W = $clog2(SCREEN_H);  // 8 bits
    localparam int C_W = 3;

    // Default colour code that the sprite ROMs use for "see-through".
    localparam logic [C_W-1:0] TRANSP_COLOUR_DEF = 3'b111;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DRAW,
        ST_GAP,
        ST_FIN
    } state_t;

endpackage

// File: rtl/draw_sequencer_pixel_mux.sv
// Picks the active draw block's x/y/colour off the flattened buses and
// delays x/y/enable by one cycle to line up with the registered ROM colour.
module layer_pixel_mux
    import draw_sequencer_pkg::*;
#(
    parameter int N_LAYERS = 4,
    parameter int CUR_W    = 2
) (
    input  logic                      clock_all,
    input  logic                      reset_all,
    input  logic [CUR_W-1:0]          cur_i,
    input  logic                      en_i,
    input  logic [X_W*N_LAYERS-1:0]   layer_x_i,
    input  logic [Y_W*N_LAYERS-1:0]   layer_y_i,
    input  logic [C_W*N_LAYERS-1:0]   layer_colour_i,
    output logic [X_W-1:0]            d_x_o,
    output logic [Y_W-1:0]            d_y_o,
    output logic                      d_en_o,
    output logic [C_W-1:0]            colour_o
);

    logic [X_W-1:0] d_x_q;
    logic [Y_W-1:0] d_y_q;
    logic           d_en_q;

    // Register the selected coordinates and the enable (one pipeline stage).
    always_ff @(posedge clock_all) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset_all) begin
            d_x_q  <= '0;
            d_y_q  <= '0;
            d_en_q <= 1'b0;
        end else begin
            d_x_q  <= layer_x_i[cur_i*X_W +: X_W];
            d_y_q  <= layer_y_i[cur_i*Y_W +: Y_W];
            d_en_q <= en_i;
        end
    end

    // The ROM colour is already one cycle behind its x/y, so it is not delayed.
    assign colour_o = layer_colour_i[cur_i*C_W +: C_W];
    assign d_x_o    = d_x_q;
    assign d_y_o    = d_y_q;
    assign d_en_o   = d_en_q;

endmodule

// File: rtl/draw_sequencer.sv
// Walks the enabled draw-block layers in slot order, one at a time, and
// merges their pixel streams into a single write stream for the VGA adapter.
module draw_sequencer
    import draw_sequencer_pkg::*;
#(
    parameter int             N_LAYERS      = 4,
    parameter logic [C_W-1:0] TRANSP_COLOUR = TRANSP_COLOUR_DEF,
    parameter bit             TRANSP_EN     = 1'b1
) (
    input  logic                    clock_all,
    input  logic                    reset_all,
    input  logic                    start,
    input  logic [N_LAYERS-1:0]     layer_mask,
    input  logic [N_LAYERS-1:0]     layer_done,
    input  logic [X_W*N_LAYERS-1:0] layer_x,
    input  logic [Y_W*N_LAYERS-1:0] layer_y,
    input  logic [C_W*N_LAYERS-1:0] layer_colour,
    output logic [N_LAYERS-1:0]     layer_enable,
    output logic [X_W-1:0]          vga_x,
    output logic [Y_W-1:0]          vga_y,
    output logic [C_W-1:0]          vga_colour,
    output logic                    vga_plot,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int               CUR_W    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam logic [CUR_W-1:0] LAST_CUR = CUR_W'(N_LAYERS - 1);

    state_t              state_q, state_d;
    logic [N_LAYERS-1:0] mask_q, mask_d;
    logic [CUR_W-1:0]    cur_q, cur_d;

    logic                sel_found;
    logic [CUR_W-1:0]    sel_idx;

    logic [C_W-1:0]      sel_colour;
    logic                d_en;

    // State, latched mask and current slot registers.
    always_ff @(posedge clock_all) begin
        if (!reset_all) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
        end
    end

    // Lowest requested layer at or above the current slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_found = 1'b0;
        sel_idx   = cur_q;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(cur_q))) begin
                sel_found = 1'b1;
                sel_idx   = CUR_W'(i);
            end
        end
    end

    // Next-state logic and the FSM-driven outputs.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cur_d        = cur_q;
        layer_enable = '0;
        frame_done   = 1'b0;
        busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = layer_mask;
                    cur_d   = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_found) begin
                    cur_d   = sel_idx;
                    state_d = ST_DRAW;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_DRAW: begin
                layer_enable[cur_q] = 1'b1;
                if (layer_done[cur_q]) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // cur holds here so the last ROM colour of this layer drains.
                if (cur_q == LAST_CUR) begin
                    state_d = ST_FIN;
                end else begin
                    cur_d   = cur_q + 1'b1;
                    state_d = ST_SELECT;
                end
            end
            ST_FIN: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    layer_pixel_mux #(
        .N_LAYERS (N_LAYERS),
        .CUR_W    (CUR_W)
    ) u_pixel_mux (
        .clock_all      (clock_all),
        .reset_all      (reset_all),
        .cur_i          (cur_q),
        .en_i           (state_q == ST_DRAW),
        .layer_x_i      (layer_x),
        .layer_y_i      (layer_y),
        .layer_colour_i (layer_colour),
        .d_x_o          (vga_x),
        .d_y_o          (vga_y),
        .d_en_o         (d_en),
        .colour_o       (sel_colour)
    );

    // Colour bus is blanked whenever no pixel is in flight, so it reads 0 in reset.
    assign vga_colour = d_en ? sel_colour : '0;

    // Layer 0 is the opaque backdrop; upper layers may skip see-through pixels.
    assign vga_plot = d_en &&
                      !(TRANSP_EN && (cur_q != '0) && (sel_colour == TRANSP_COLOUR));

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer with simple counter-based draw-block stubs.
module tb_draw_sequencer;
    import draw_sequencer_pkg::*;

    localparam int NL = 4;

    logic                  clock_all = 1'b0;
    logic                  reset_all = 1'b0;
    logic                  start     = 1'b0;
    logic [NL-1:0]         layer_mask = '0;
    logic [NL-1:0]         layer_done;
    logic [X_W*NL-1:0]     layer_x;
    logic [Y_W*NL-1:0]     layer_y;
    logic [C_W*NL-1:0]     layer_colour;
    logic [NL-1:0]         layer_enable;
    logic [X_W-1:0]        vga_x;
    logic [Y_W-1:0]        vga_y;
    logic [C_W-1:0]        vga_colour;
    logic                  vga_plot;
    logic                  busy;
    logic                  frame_done;

    draw_sequencer #(.N_LAYERS(NL)) dut (
        .clock_all    (clock_all),
        .reset_all    (reset_all),
        .start        (start),
        .layer_mask   (layer_mask),
        .layer_done   (layer_done),
        .layer_x      (layer_x),
        .layer_y      (layer_y),
        .layer_colour (layer_colour),
        .layer_enable (layer_enable),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clock_all = ~clock_all;

    // ---------------- draw-block stubs ----------------
    int             w[NL]     = '{4, 4, 4, 4};
    int             h[NL]     = '{2, 2, 2, 2};
    bit             tmode[NL] = '{0, 0, 0, 0};
    logic [NL-1:0]  spur      = '0;
    logic [X_W-1:0] sx[NL]    = '{default: '0};
    logic [Y_W-1:0] sy[NL]    = '{default: '0};
    logic [C_W-1:0] sc[NL]    = '{default: '0};

    // Stub ROM: colour is x[2:0], or see-through on even x when tmode is set.
    function automatic logic [C_W-1:0] stub_colour(int slot, logic [X_W-1:0] x);
        return (tmode[slot] && !x[0]) ? 3'b111 : x[2:0];
    endfunction

    always @(posedge clock_all) begin
        for (int i = 0; i < NL; i++) begin
            sc[i] <= stub_colour(i, sx[i]);
            if (!layer_enable[i]) begin
                sx[i] <= '0;
                sy[i] <= '0;
            end else if (sx[i] == X_W'(w[i] - 1)) begin
                sx[i] <= '0;
                sy[i] <= (sy[i] == Y_W'(h[i] - 1)) ? '0 : sy[i] + 1'b1;
            end else begin
                sx[i] <= sx[i] + 1'b1;
            end
        end
    end

    always_comb begin
        layer_x      = '0;
        layer_y      = '0;
        layer_colour = '0;
        layer_done   = '0;
        for (int i = 0; i < NL; i++) begin
            layer_x[i*X_W +: X_W]      = sx[i];
            layer_y[i*Y_W +: Y_W]      = sy[i];
            layer_colour[i*C_W +: C_W] = sc[i];
            layer_done[i] = ((sx[i] == X_W'(w[i] - 1)) && (sy[i] == Y_W'(h[i] - 1))) | spur[i];
        end
    end

    // ---------------- checking ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } pix_t;

    pix_t sb_q[$];

    int cyc = 0;
    always @(posedge clock_all) cyc <= cyc + 1;

    int en_cnt[NL], first_en[NL], last_en[NL];
    int plot_cnt, done_cnt, done_cyc, start_cyc, busy_cnt, last_plot_cyc, overlap;
    logic [X_W+Y_W-1:0] last_plot_xy;

    // Monitor: samples on the falling edge and pops the scoreboard per plot.
    always @(negedge clock_all) begin
        pix_t e;
        if (reset_all && start && !busy) start_cyc = cyc;
        if (busy) busy_cnt++;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if ($countones(layer_enable) > 1) overlap++;
        for (int i = 0; i < NL; i++) begin
            if (layer_enable[i]) begin
                if (en_cnt[i] == 0) first_en[i] = cyc;
                en_cnt[i]++;
                last_en[i] = cyc;
            end
        end
        if (vga_plot) begin
            plot_cnt++;
            last_plot_cyc = cyc;
            last_plot_xy  = {vga_x, vga_y};
            check("align_colour_vs_x", vga_colour, vga_x[2:0]);
            check("sb_entry_available", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pixel_xyc", {vga_x, vga_y, vga_colour}, e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_all);
            #1;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NL; i++) begin
            en_cnt[i] = 0; first_en[i] = -1; last_en[i] = -1;
        end
        plot_cnt = 0; done_cnt = 0; done_cyc = -1; start_cyc = -1;
        busy_cnt = 0; last_plot_cyc = -1; overlap = 0; last_plot_xy = '0;
        sb_q.delete();
    endtask

    task automatic push_layer(input int slot);
        pix_t p;
        for (int y = 0; y < h[slot]; y++) begin
            for (int x = 0; x < w[slot]; x++) begin
                p.x = X_W'(x);
                p.y = Y_W'(y);
                p.c = stub_colour(slot, X_W'(x));
                if (!(slot != 0 && p.c == 3'b111)) sb_q.push_back(p);
            end
        end
    endtask

    task automatic pulse_start(input logic [NL-1:0] mask);
        layer_mask = mask;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1);
            n++;
        end
        check(name, done_cnt > d0, 1);
        step(2);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        pix_t p;
        clear_stats();
        reset_all = 1'b0;
        step(3);
        check("rst_enable", layer_enable, 0);
        check("rst_busy_done", {busy, frame_done}, 0);
        check("rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
        reset_all = 1'b1;
        step(2);

        // Reset mid-frame: only x=0..2 of row 0 reach the adapter.
        clear_stats();
        w[0] = 4; h[0] = 2;
        for (int x = 0; x < 3; x++) begin
            p.x = X_W'(x); p.y = '0; p.c = C_W'(x);
            sb_q.push_back(p);
        end
        pulse_start(4'b0001);
        step(4);
        reset_all = 1'b0;
        step(1);
        check("midrst_enable", layer_enable, 0);
        check("midrst_busy_done", {busy, frame_done}, 0);
        check("midrst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
        reset_all = 1'b1;
        step(3);
        check("midrst_no_frame_done", done_cnt, 0);
        check("midrst_plot_cnt", plot_cnt, 3);
        check("midrst_sb_drained", sb_q.size(), 0);

        clear_stats();
        push_layer(0);
        pulse_start(4'b0001);
        wait_frame("after_rst_frame_done", 100);
        check("after_rst_en_cnt", en_cnt[0], 8);
        check("after_rst_plot_cnt", plot_cnt, 8);
        check("after_rst_sb_drained", sb_q.size(), 0);

        // Single full-screen layer.
        clear_stats();
        w[0] = SCREEN_W; h[0] = SCREEN_H;
        push_layer(0);
        pulse_start(4'b0001);
        wait_frame("full_frame_done", 80000);
        check("full_en_cnt", en_cnt[0], 76800);
        check("full_plot_cnt", plot_cnt, 76800);
        check("full_last_xy", last_plot_xy, {9'd319, 8'd239});
        check("full_last_plot_cyc", last_plot_cyc - last_en[0], 1);
        check("full_done_cyc", done_cyc - last_en[0], 3);
        check("full_first_en", first_en[0] - start_cyc, 2);
        check("full_sb_drained", sb_q.size(), 0);

        // Two layers, layer 2 see-through on even x.
        clear_stats();
        w[0] = 4; h[0] = 2;
        w[2] = 4; h[2] = 2; tmode[2] = 1;
        push_layer(0);
        push_layer(2);
        pulse_start(4'b0101);
        wait_frame("two_frame_done", 200);
        check("two_en0_cnt", en_cnt[0], 8);
        check("two_en2_cnt", en_cnt[2], 8);
        check("two_plot_cnt", plot_cnt, 12);
        check("two_no_overlap", overlap, 0);
        check("two_en2_after_gap_select", first_en[2] - last_en[0], 3);
        check("two_done_cyc", done_cyc - last_en[2], 3);
        check("two_sb_drained", sb_q.size(), 0);
        tmode[2] = 0;

        // Empty mask.
        clear_stats();
        pulse_start(4'b0000);
        wait_frame("empty_frame_done", 20);
        check("empty_done_latency", done_cyc - start_cyc, 2);
        check("empty_busy_cycles", busy_cnt, 2);
        check("empty_no_plot", plot_cnt, 0);

        // Start while busy plus a spurious done on a non-current layer.
        clear_stats();
        push_layer(0);
        pulse_start(4'b0001);
        step(2);
        layer_mask = 4'b1000;
        start      = 1'b1;
        spur[3]    = 1'b1;
        step(1);
        start      = 1'b0;
        spur       = '0;
        wait_frame("busy_frame_done", 100);
        step(10);
        check("busy_single_frame", done_cnt, 1);
        check("busy_en0_cnt", en_cnt[0], 8);
        check("busy_en3_cnt", en_cnt[3], 0);
        check("busy_plot_cnt", plot_cnt, 8);
        check("busy_done_cyc", done_cyc - last_en[0], 3);
        check("busy_idle_after", busy, 0);
        check("busy_sb_drained", sb_q.size(), 0);

        // Only the last slot: GAP goes straight to FIN.
        clear_stats();
        w[3] = 3; h[3] = 1;
        push_layer(3);
        pulse_start(4'b1000);
        wait_frame("last_frame_done", 50);
        check("last_en3_cnt", en_cnt[3], 3);
        check("last_plot_cnt", plot_cnt, 3);
        check("last_first_en", first_en[3] - start_cyc, 2);
        check("last_done_cyc", done_cyc - last_en[3], 2);
        check("last_sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Sits directly downstream of the full-screen and sprite draw blocks (win screen, background, battle sprites) and directly upstream of the VGA adapter.
- On a start pulse it enables one draw block at a time in fixed layer order and waits for each block's done.
- It re-times that block's x/y to match the colour coming out of its ROM, then drives one pixel-write stream (x, y, colour, plot) to the VGA adapter.

Parameters:
- N_LAYERS, 4, number of draw-block slots; slot 0 is drawn first.
- TRANSP_COLOUR, 3'b111, colour value treated as transparent.
- TRANSP_EN, 1, when 1, transparent pixels on layers 1..N_LAYERS-1 are not plotted; layer 0 is always fully plotted.

Ports:
- clock_all  input  1  system clock; all logic on the rising edge.
- reset_all  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to draw a frame; ignored while busy.
- layer_mask  input  N_LAYERS  sampled on an accepted start; bit i=1 means draw layer i.
- layer_done  input  N_LAYERS  done from each draw block; high while its counters sit on the last pixel.
- layer_x  input  9*N_LAYERS  flattened x from each block; slot i is bits [9i+8:9i].
- layer_y  input  8*N_LAYERS  flattened y from each block; slot i is bits [8i+7:8i].
- layer_colour  input  3*N_LAYERS  flattened ROM colour from each block; valid one cycle after its x/y.
- layer_enable  output  N_LAYERS  one-hot enable to the draw blocks; all zero when no layer is active.
- vga_x  output  9  pixel x to the VGA adapter.
- vga_y  output  8  pixel y to the VGA adapter.
- vga_colour  output  3  pixel colour to the VGA adapter.
- vga_plot  output  1  write strobe to the VGA adapter.
- busy  output  1  high from an accepted start until frame_done.
- frame_done  output  1  one-cycle pulse when the frame is finished.

Behaviour:
- Reset (reset_all=0 at an edge): state IDLE; all outputs 0; the latched mask is cleared.
  - Reset mid-frame aborts the frame with no frame_done.
  - Draw blocks see enable=0, so their counters return to 0.
- FSM states: IDLE, SELECT, DRAW, GAP, FIN.
- IDLE:
  - start=1: latch layer_mask, set cur=0, go to SELECT, busy=1 from the next cycle.
- SELECT:
  - Finds the lowest set bit of latched mask at index >= cur.
  - If found: cur takes that index, go to DRAW.
  - If none: go to FIN.
  - Takes 1 cycle; no enables asserted.
- DRAW:
  - layer_enable[cur]=1; all other enable bits are 0.
  - If layer_done[cur]=1 in a DRAW cycle: the next state is GAP and enable drops on the following cycle.
  - A layer therefore gets exactly W*H enable cycles, the done cycle included.
- GAP:
  - Lasts 1 cycle with no enables; this lets the last ROM colour drain.
  - Then cur=cur+1 and go to SELECT.
  - If cur was N_LAYERS-1, go to FIN instead.
- FIN: frame_done=1 for 1 cycle, busy goes to 0, return to IDLE.
- Pixel path (one pipeline stage):
  - Each cycle, register layer_x/layer_y[cur] and the current enable into d_x, d_y, d_en.
  - vga_x=d_x; vga_y=d_y; vga_colour=layer_colour[cur], taken directly since the ROM output is already registered.
  - vga_plot=d_en, except forced to 0 when TRANSP_EN=1, cur!=0 and colour==TRANSP_COLOUR.
  - cur stays stable through GAP, so the last pixel of each layer is plotted in the GAP cycle.
  - Plot count per layer equals its enable count minus transparent pixels.
- Simultaneous events:
  - start while busy: ignored.
  - layer_done for a non-current layer: ignored.
  - layer_done[cur] in SELECT or GAP: ignored.
- layer_mask=0 at start: IDLE→SELECT→FIN; frame_done 2 cycles after start; no plots.
- Arithmetic: no adds on the pixel path; x/y pass through unchanged (9/8 bits). cur is clog2(N_LAYERS) bits and never exceeds N_LAYERS-1.

Decomposition:
- Shared package: the state encoding (IDLE..FIN), TRANSP_COLOUR default, screen constants SCREEN_W=320 and SCREEN_H=240, and the X_W=9, Y_W=8, C_W=3 widths.
- One natural sub-module: layer_pixel_mux. It selects slot cur from the flattened buses and registers x/y/enable into d_x/d_y/d_en. The FSM stays in draw_sequencer.

Test Plan:
- Reset mid-frame: start with mask=4'b0001 using a 4x2 stub drawer, then pull reset_all low at cycle 5 → all outputs 0 on the next edge, no frame_done, and a later start draws all 8 pixels.
- Single full layer: mask=4'b0001 with a 320x240 stub → layer_enable[0] high exactly 76800 cycles, vga_plot high exactly 76800 cycles, last plot shows (319,239) one cycle after done, frame_done 3 cycles after the last enable cycle.
- Two layers with transparency: mask=4'b0101, layer 2 is a 4x2 stub whose colour is 3'b111 on even x → layer 0 plots all pixels, layer 2 plots 4 of 8, enable[2] never overlaps enable[0] and follows after a 1-cycle GAP plus 1-cycle SELECT.
- Empty mask: start with mask=0 → frame_done at start+2, busy high for 2 cycles, vga_plot never high.
- Start while busy, plus a spurious done: pulse start again mid-layer and pulse layer_done[3] while layer 0 is active → neither changes state, enable or the frame.
- Alignment: the stub's colour encodes x[2:0] with a 1-cycle latency → in every plotted cycle, vga_colour==vga_x[2:0].
